// File: rtl/des_pkg.sv
// Shared DES tables, state encoding and permutation helpers.
// Imported by des_round and des_iter_core; no ports.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [27:0] c;
    logic [27:0] d;
  } des_st_t;

  // Left shifts walk K1..K16; right shifts walk K16..K1.
  localparam int SHL_T [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SHR_T [16] = '{
    0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed [box][{row, col}], row = {b1,b6}, col = b2..b5.
  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Tables use DES numbering: entry n names input bit n, bit 1 = MSB.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] perm_ip_inv(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-IPI_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55-i)] = x[6'(64-PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47-i)] = x[6'(56-PC2_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47-i)] = x[5'(32-E_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31-i)] = x[5'(32-P_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] f_func(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = perm_e(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(42-6*j) +: 6];
      s[5'(28-4*j) +: 4] = 4'(SBOX_T[j][{b[5], b[0], b[4:1]}]);
    end
    return perm_p(s);
  endfunction

  function automatic logic [27:0] rotl28(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: rotate C/D, derive K_i via PC-2, Feistel step.
// Ports: st_i/st_o {L,R,C,D}, decrypt_i selects rotate direction, rnd_i 0..15.
module des_round
  import des_pkg::*;
(
  input  des_st_t    st_i,
  input  logic       decrypt_i,
  input  logic [3:0] rnd_i,
  output des_st_t    st_o
);

  logic [1:0]  sh;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [47:0] k;

  // Decrypt rotates right so the schedule yields K16..K1 in order.
  always_comb begin
    sh = decrypt_i ? 2'(SHR_T[rnd_i]) : 2'(SHL_T[rnd_i]);
    c_rot = decrypt_i ? rotr28(st_i.c, sh) : rotl28(st_i.c, sh);
    d_rot = decrypt_i ? rotr28(st_i.d, sh) : rotl28(st_i.d, sh);
    k = perm_pc2({c_rot, d_rot});
    st_o.l = st_i.r;
    st_o.r = st_i.l ^ f_func(st_i.r, k);
    st_o.c = c_rot;
    st_o.d = d_rot;
  end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine, ROUNDS_PER_CYCLE rounds per clock, enc/dec per block.
// Ports: clk, rst; in_valid/in_ready/in_decrypt/in_data/in_key;
//        out_valid/out_ready/out_data; busy (RUN or DONE).
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int RPC   = ROUNDS_PER_CYCLE;
  localparam int ITERS = 16 / RPC;

  // Only divisors of 16 give an exact round count.
  if (ITERS * RPC != 16) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e      state_q, state_d;
  logic [4:0]  rnd_q, rnd_d;
  des_st_t     st_q, st_d;
  logic        dec_q, dec_d;
  logic [63:0] out_q, out_d;
  des_st_t     st_last;

  for (genvar g = 0; g < RPC; g++) begin : g_rnd
    des_st_t    st_in;
    des_st_t    st_out;
    logic [3:0] idx;

    // rnd_q is a multiple of RPC, so this never wraps.
    assign idx = rnd_q[3:0] + 4'(g);

    if (g == 0) begin : g_head
      assign st_in = st_q;
    end else begin : g_link
      assign st_in = g_rnd[g-1].st_out;
    end

    des_round u_round (
      .st_i      (st_in),
      .decrypt_i (dec_q),
      .rnd_i     (idx),
      .st_o      (st_out)
    );
  end

  assign st_last = g_rnd[RPC-1].st_out;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    dec_d   = dec_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          {st_d.l, st_d.r} = perm_ip(in_data);
          {st_d.c, st_d.d} = perm_pc1(in_key);
          dec_d   = in_decrypt;
          rnd_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        st_d  = st_last;
        rnd_d = rnd_q + 5'(RPC);
        if (rnd_d == 5'd16) begin
          // Final swap: output is IP^-1 of {R16, L16}.
          out_d   = perm_ip_inv({st_last.r, st_last.l});
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      dec_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core at all legal ROUNDS_PER_CYCLE values.
// Instances share data inputs; each has its own in_valid and outputs.
module tb_des_iter_core;
  import des_pkg::*;

  localparam int NI = 5;
  localparam int RPC_T [NI] = '{1, 2, 4, 8, 16};

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic          in_decrypt;
  logic [63:0]   in_data;
  logic [63:0]   in_key;
  logic [NI-1:0] out_valid;
  logic          out_ready;
  logic [63:0]   out_data [NI];
  logic [NI-1:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(RPC_T[g])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_decrypt (in_decrypt),
      .in_data    (in_data),
      .in_key     (in_key),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_data   (out_data[g]),
      .busy       (busy[g])
    );
  end

  // Textbook DES: precomputed K1..K16, reversed for decrypt.
  function automatic logic [63:0] des_ref(
    input logic [63:0] key,
    input logic [63:0] blk,
    input logic        dec
  );
    int          sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    cd = perm_pc1(key);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < sh[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = perm_pc2({c, d});
    end
    {l, r} = perm_ip(blk);
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_func(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return perm_ip_inv({r, l});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    in_decrypt = 1'b0;
    in_data = '0;
    in_key = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 ||
          busy[i] !== 1'b0 || out_data[i] !== 64'h0) begin
        failures++;
        $display("FAIL reset[%0d] rdy=%b ov=%b busy=%b od=%h exp 1/0/0/0",
                 i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One block into every instance at once; checks per-instance latency.
  task automatic run_all(
    input logic [63:0] key,
    input logic [63:0] din,
    input logic        dec,
    input logic [63:0] exp,
    input string       name
  );
    int lat [NI];
    int n;
    bit pend;
    for (int i = 0; i < NI; i++) lat[i] = -1;
    @(negedge clk);
    checks++;
    if (in_ready !== '1) begin
      failures++;
      $display("FAIL %s_ready got=%b exp=11111", name, in_ready);
    end
    in_key = key;
    in_data = din;
    in_decrypt = dec;
    in_valid = '1;
    @(negedge clk);
    in_valid = '0;
    in_key = ~key;
    in_data = ~din;
    in_decrypt = ~dec;
    n = 0;
    pend = 1'b1;
    while (pend && n < 40) begin
      @(negedge clk);
      n++;
      pend = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && out_valid[i]) lat[i] = n;
        if (lat[i] < 0) pend = 1'b1;
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (lat[i] != 16 / RPC_T[i]) begin
        failures++;
        $display("FAIL %s_lat rpc=%0d got=%0d exp=%0d",
                 name, RPC_T[i], lat[i], 16 / RPC_T[i]);
      end
      checks++;
      if (out_data[i] !== exp) begin
        failures++;
        $display("FAIL %s_data rpc=%0d got=%h exp=%h",
                 name, RPC_T[i], out_data[i], exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== '1 || out_valid !== '0) begin
      failures++;
      $display("FAIL %s_release rdy=%b ov=%b exp=11111/00000",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_known();
    run_all(K1, P1, 1'b0, C1, "kat_enc1");
    run_all(K1, C1, 1'b1, P1, "kat_dec1");
    run_all(K2, P2, 1'b0, 64'h0, "kat_enc2");
    run_all(K2, 64'h0, 1'b1, P2, "kat_dec2");
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    in_key = K1;
    in_data = P1;
    in_decrypt = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    // Second block offered while the first is held in DONE.
    in_data = C1;
    in_decrypt = 1'b1;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
          out_data[0] !== C1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d ov=%b rdy=%b od=%h exp 1/0/%h",
                 c, out_valid[0], in_ready[0], out_data[0], C1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle rdy=%b ov=%b exp 1/0", in_ready[0], out_valid[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept busy=%b exp=1", busy[0]);
    end
    n = 0;
    while (!out_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16 || out_data[0] !== P1) begin
      failures++;
      $display("FAIL bp_second lat=%0d od=%h exp 16/%h", n, out_data[0], P1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    in_key = K2;
    in_data = P2;
    in_decrypt = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== '1 || out_valid !== '0 || busy !== '0 ||
        out_data[0] !== 64'h0) begin
      failures++;
      $display("FAIL rst_mid rdy=%b ov=%b busy=%b od=%h exp 11111/0/0/0",
               in_ready, out_valid, busy, out_data[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_mid_no_ov got=1 exp=0");
    end
    run_all(K2, P2, 1'b0, 64'h0, "post_rst");
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [63:0] key, din, exp;
    logic        dec;
    out_ready = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom, $urandom};
      din = {$urandom, $urandom};
      dec = 1'($urandom);
      exp = des_ref(key, din, dec);
      checks++;
      if (in_ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready blk=%0d got=%b exp=1", b, in_ready[0]);
      end
      in_key = key;
      in_data = din;
      in_decrypt = dec;
      in_valid[0] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid[0] && n < 40);
      checks++;
      if (n != 17) begin
        failures++;
        $display("FAIL b2b_lat blk=%0d got=%0d exp=17", b, n);
      end
      checks++;
      if (out_data[0] !== exp) begin
        failures++;
        $display("FAIL b2b_data blk=%0d dec=%b got=%h exp=%h",
                 b, dec, out_data[0], exp);
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_known();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
